// File: rtl/count_stim_gen.sv
// Command-driven En/Slt stimulus generator with a shadow model (Exp0/Exp1) of the dual event counter.
// Optional feature: define STIM_GAP_EN to insert one idle GAP cycle after every En pulse.
module count_stim_gen #(
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 4,
  parameter int EXP_W    = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Cmd_Valid,
  output logic             Cmd_Ready,
  input  logic [CNT_W-1:0] Cmd_N0,
  input  logic [CNT_W-1:0] Cmd_N1,
  input  logic             Abort,
  output logic             En,
  output logic             Slt,
  output logic             Busy,
  output logic             Done,
  output logic [EXP_W-1:0] Exp0,
  output logic [EXP_W-1:0] Exp1
);

  localparam int PH_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, RUN0, RUN1, GAP, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem0_q, rem0_d, rem1_q, rem1_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [EXP_W-1:0] exp0_q, exp0_d, exp1_q, exp1_d;
  logic             en_q, slt_q, done_q;

  function automatic state_t pickRun(input logic [CNT_W-1:0] r0, input logic [CNT_W-1:0] r1);
    if (r0 != '0) return RUN0;
    if (r1 != '0) return RUN1;
    return FIN;
  endfunction

  // Model bookkeeping happens on the edge that ends each pulse cycle, so an
  // aborted pulse that was already driven is still counted.
  always_comb begin
    state_d = state_q;
    rem0_d  = rem0_q;
    rem1_d  = rem1_q;
    phase_d = phase_q;
    exp0_d  = exp0_q;
    exp1_d  = exp1_q;
    case (state_q)
      IDLE: begin
        if (Cmd_Valid) begin
          rem0_d  = Cmd_N0;
          rem1_d  = Cmd_N1;
          state_d = pickRun(Cmd_N0, Cmd_N1);
        end
      end
      RUN0: begin
        exp0_d = exp0_q + 1'b1;
        rem0_d = rem0_q - 1'b1;
`ifdef STIM_GAP_EN
        state_d = GAP;
`else
        state_d = pickRun(rem0_d, rem1_q);
`endif
      end
      RUN1: begin
        if (phase_q == PH_LAST) begin
          phase_d = '0;
          exp1_d  = exp1_q + 1'b1;
          rem1_d  = rem1_q - 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
`ifdef STIM_GAP_EN
        state_d = GAP;
`else
        state_d = pickRun(rem0_q, rem1_d);
`endif
      end
`ifdef STIM_GAP_EN
      GAP:     state_d = pickRun(rem0_q, rem1_q);
`endif
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Abort && (state_q == RUN0 || state_q == RUN1 || state_q == GAP)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      rem0_q  <= '0;
      rem1_q  <= '0;
      phase_q <= '0;
      exp0_q  <= '0;
      exp1_q  <= '0;
      en_q    <= 1'b0;
      slt_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem0_q  <= rem0_d;
      rem1_q  <= rem1_d;
      phase_q <= phase_d;
      exp0_q  <= exp0_d;
      exp1_q  <= exp1_d;
      en_q    <= (state_d == RUN0) || (state_d == RUN1);
      slt_q   <= (state_d == RUN1);
      done_q  <= (state_d == FIN);
    end
  end

  assign Cmd_Ready = (state_q == IDLE);
  assign Busy      = (state_q != IDLE);
  assign En        = en_q;
  assign Slt       = slt_q;
  assign Done      = done_q;
  assign Exp0      = exp0_q;
  assign Exp1      = exp1_q;

endmodule

// File: tb/tb_count_stim_gen.sv
// Directed bench for count_stim_gen: table of commands plus hand-written abort and reset sequences.
// Small CNT_W/EXP_W so maximum-size commands and Exp wrap-around stay short.
module tb_count_stim_gen;

  localparam int CNT_W    = 4;
  localparam int PRESCALE = 4;
  localparam int EXP_W    = 5;
`ifdef STIM_GAP_EN
  localparam int GAP = 1;
`else
  localparam int GAP = 0;
`endif

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic             Cmd_Valid = 1'b0;
  logic             Cmd_Ready;
  logic [CNT_W-1:0] Cmd_N0 = '0;
  logic [CNT_W-1:0] Cmd_N1 = '0;
  logic             Abort = 1'b0;
  logic             En, Slt, Busy, Done;
  logic [EXP_W-1:0] Exp0, Exp1;

  int checks = 0;
  int errors = 0;

  count_stim_gen #(.CNT_W(CNT_W), .PRESCALE(PRESCALE), .EXP_W(EXP_W)) dut (
    .Clk(Clk), .Reset(Reset), .Cmd_Valid(Cmd_Valid), .Cmd_Ready(Cmd_Ready),
    .Cmd_N0(Cmd_N0), .Cmd_N1(Cmd_N1), .Abort(Abort), .En(En), .Slt(Slt),
    .Busy(Busy), .Done(Done), .Exp0(Exp0), .Exp1(Exp1)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [CNT_W-1:0] n0;
    logic [CNT_W-1:0] n1;
    int               en0;
    int               slt;
    int               doneCyc;
    logic [EXP_W-1:0] exp0;
    logic [EXP_W-1:0] exp1;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Issues one command and watches it to completion (or to the abort point).
  // abortAfter>0 raises Abort in the cycle where that many pulses have been seen.
  task automatic applyStimulus(input string tag, input logic [CNT_W-1:0] n0, input logic [CNT_W-1:0] n1,
                               input int abortAfter, input int expEn0, input int expSlt, input int expDone,
                               input logic [EXP_W-1:0] e0, input logic [EXP_W-1:0] e1);
    int en0 = 0, slt = 0, doneCyc = 0, doneCnt = 0, busyLow = 0, sltNoEn = 0;
    bit fin = 0, aborted = 0;
    @(negedge Clk);
    checkOutput({tag, " ready"}, 64'(Cmd_Ready), 64'd1);
    Cmd_Valid = 1'b1;
    Cmd_N0 = n0;
    Cmd_N1 = n1;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge Clk);
      Cmd_N0 = '1;
      Cmd_N1 = '1;
      if (aborted) begin
        Abort = 1'b0;
        checkOutput({tag, " abort En"}, 64'(En), 64'd0);
        checkOutput({tag, " abort Busy"}, 64'(Busy), 64'd0);
        checkOutput({tag, " abort Ready"}, 64'(Cmd_Ready), 64'd1);
        if (Done) doneCnt++;
        fin = 1;
      end else if (doneCnt > 0) begin
        checkOutput({tag, " post Ready"}, 64'(Cmd_Ready), 64'd1);
        checkOutput({tag, " post Done"}, 64'(Done), 64'd0);
        fin = 1;
      end else begin
        if (En && !Slt) en0++;
        if (En && Slt) slt++;
        if (Slt && !En) sltNoEn++;
        if (!Busy) busyLow++;
        if (Done) begin
          doneCnt++;
          doneCyc = cyc;
          Cmd_Valid = 1'b0;
        end
        if (abortAfter > 0 && en0 + slt == abortAfter) begin
          Abort = 1'b1;
          Cmd_Valid = 1'b0;
          aborted = 1;
        end
      end
    end
    Cmd_Valid = 1'b0;
    Abort = 1'b0;
    checkOutput({tag, " finished"}, 64'(fin), 64'd1);
    checkOutput({tag, " En0 pulses"}, 64'(en0), 64'(expEn0));
    checkOutput({tag, " Slt pulses"}, 64'(slt), 64'(expSlt));
    checkOutput({tag, " Slt without En"}, 64'(sltNoEn), 64'd0);
    checkOutput({tag, " Busy low"}, 64'(busyLow), 64'd0);
    checkOutput({tag, " Done count"}, 64'(doneCnt), (abortAfter > 0) ? 64'd0 : 64'd1);
    if (abortAfter == 0)
      checkOutput({tag, " Done cycle"}, 64'(doneCyc),
                  (GAP != 0) ? 64'(2 * (expEn0 + expSlt) + 1) : 64'(expDone));
    checkOutput({tag, " Exp0"}, 64'(Exp0), 64'(e0));
    checkOutput({tag, " Exp1"}, 64'(Exp1), 64'(e1));
  endtask

  initial begin
    vecs[0] = '{4'd3,  4'd0,  3,  0,  4,  5'd3,  5'd0};
    vecs[1] = '{4'd0,  4'd2,  0,  8,  9,  5'd3,  5'd2};
    vecs[2] = '{4'd0,  4'd0,  0,  0,  1,  5'd3,  5'd2};
    vecs[3] = '{4'd2,  4'd1,  2,  4,  7,  5'd5,  5'd3};
    vecs[4] = '{4'd15, 4'd15, 15, 60, 76, 5'd20, 5'd18};
    vecs[5] = '{4'd15, 4'd0,  15, 0,  16, 5'd3,  5'd18};
    vecs[6] = '{4'd1,  4'd4,  1,  16, 18, 5'd4,  5'd22};
    vecs[7] = '{4'd0,  4'd15, 0,  60, 61, 5'd4,  5'd5};

    #12;
    checkOutput("reset En", 64'(En), 64'd0);
    checkOutput("reset Slt", 64'(Slt), 64'd0);
    checkOutput("reset Busy", 64'(Busy), 64'd0);
    checkOutput("reset Done", 64'(Done), 64'd0);
    checkOutput("reset Ready", 64'(Cmd_Ready), 64'd1);
    checkOutput("reset Exp0", 64'(Exp0), 64'd0);
    checkOutput("reset Exp1", 64'(Exp1), 64'd0);
    @(negedge Clk);
    Reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].n0, vecs[i].n1, 0,
                    vecs[i].en0, vecs[i].slt, vecs[i].doneCyc, vecs[i].exp0, vecs[i].exp1);
    end

    // Abort mid-RUN1 leaves phase at 2, so the follow-up N1=1 needs only 2 pulses.
    applyStimulus("abortRun1", 4'd0, 4'd1, 2, 0, 2, 0, 5'd4, 5'd5);
    applyStimulus("resumeRun1", 4'd0, 4'd1, 0, 0, 2, 3, 5'd4, 5'd6);
    applyStimulus("abortRun0", 4'd5, 4'd0, 2, 2, 0, 0, 5'd6, 5'd6);
    applyStimulus("abortLast", 4'd2, 4'd0, 2, 2, 0, 0, 5'd8, 5'd6);

    // Asynchronous reset in the middle of a RUN1 burst.
    @(negedge Clk);
    Cmd_Valid = 1'b1;
    Cmd_N0 = 4'd0;
    Cmd_N1 = 4'd3;
    @(negedge Clk);
    Cmd_Valid = 1'b0;
    repeat (2) @(negedge Clk);
    checkOutput("midrun Slt", 64'(Slt), 64'd1);
    #2 Reset = 1'b0;
    #1;
    checkOutput("async En", 64'(En), 64'd0);
    checkOutput("async Slt", 64'(Slt), 64'd0);
    checkOutput("async Exp0", 64'(Exp0), 64'd0);
    checkOutput("async Exp1", 64'(Exp1), 64'd0);
    checkOutput("async Busy", 64'(Busy), 64'd0);
    checkOutput("async Ready", 64'(Cmd_Ready), 64'd1);
    @(negedge Clk);
    Reset = 1'b1;
    applyStimulus("afterReset", 4'd0, 4'd1, 0, 0, 4, 5, 5'd0, 5'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
